// File: rtl/nes_controller_reader.sv
// NES controller reader: drives latch/clock toward the pad, shifts in the 8 serial
// button bits and presents them active-high with a one-cycle valid strobe.
module nes_controller_reader #(
    parameter int HALF_PERIOD = 150
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       nes_data,
    output logic       nes_latch,
    output logic       nes_clk,
    output logic [7:0] buttons,
    output logic       valid,
    output logic       busy
);

    localparam int CW = $clog2(2 * HALF_PERIOD);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        WAIT,
        CLK_HI,
        CLK_LO,
        DONE
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt;
    logic [2:0]    idx, idx_d;
    logic [7:0]    shift, shift_d;
    logic          sync1, sync2;
    logic          last_full, last_half;

    // Pad data is asynchronous; idle level is high (nothing pressed).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= nes_data;
            sync2 <= sync1;
        end
    end

    assign last_full = (cnt == CW'(2 * HALF_PERIOD - 1));
    assign last_half = (cnt == CW'(HALF_PERIOD - 1));

    always_comb begin
        state_d = state;
        idx_d   = idx;
        shift_d = shift;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = LATCH;
                    idx_d   = 3'd0;
                end
            end
            LATCH: begin
                if (last_full) state_d = WAIT;
            end
            WAIT: begin
                if (last_half) begin
                    shift_d[idx] = sync2;
                    state_d      = CLK_HI;
                end
            end
            CLK_HI: begin
                if (last_half) begin
                    idx_d   = idx + 3'd1;
                    state_d = CLK_LO;
                end
            end
            CLK_LO: begin
                if (last_half) begin
                    shift_d[idx] = sync2;
                    state_d      = (idx == 3'd7) ? DONE : CLK_HI;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= 3'd0;
            shift <= 8'hFF;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            shift <= shift_d;
            if (state_d != state || state == IDLE) cnt <= '0;
            else                                   cnt <= cnt + 1'b1;
        end
    end

    // Outputs are decoded from the next state so each pin tracks its state exactly
    // while still coming straight out of a flop. buttons takes shift_d so the
    // final bit, sampled on the same edge, is included.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nes_latch <= 1'b0;
            nes_clk   <= 1'b0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            buttons   <= 8'h00;
        end else begin
            nes_latch <= (state_d == LATCH);
            nes_clk   <= (state_d == CLK_HI);
            busy      <= (state_d == LATCH) || (state_d == WAIT) ||
                         (state_d == CLK_HI) || (state_d == CLK_LO);
            valid     <= (state_d == DONE);
            if (state_d == DONE) buttons <= ~shift_d;
        end
    end

endmodule

// File: tb/tb_nes_controller_reader.sv
// Bench for nes_controller_reader: behavioural 4021-style pad model, timeline
// expectations derived from the read schedule, and a latch-time scoreboard.
module tb_nes_controller_reader;

    localparam int H   = 4;
    localparam int LAT = 17 * H + 1;
    localparam int P   = 17 * H + 2;

    logic       clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic       nes_data, nes_latch, nes_clk, valid, busy;
    logic [7:0] buttons;

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    nes_controller_reader #(.HALF_PERIOD(H)) dut (
        .clk(clk), .reset(reset), .start(start), .nes_data(nes_data),
        .nes_latch(nes_latch), .nes_clk(nes_clk), .buttons(buttons),
        .valid(valid), .busy(busy)
    );

    // Pad model: parallel load on latch, next bit on each clock rise, high after 8.
    logic [7:0] pins  = 8'hFF;
    logic [7:0] shreg = 8'hFF;
    int         bidx  = 8;
    logic [7:0] exp_q[$];

    always @(posedge nes_latch or posedge nes_clk) begin
        if (nes_latch) begin
            shreg = pins;
            bidx  = 0;
            exp_q.push_back(~pins);
        end else begin
            bidx = bidx + 1;
        end
    end
    assign nes_data = (bidx < 8) ? shreg[bidx[2:0]] : 1'b1;

    typedef struct {
        logic [7:0] pat;
        logic [7:0] exp_btn;
    } vec_t;
    vec_t tbl[6];

    int latch_rises, clk_rises, tl_err;
    int vcyc[$];
    int vbtn[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic bit exp_latch(input int r);
        return r >= 1 && r <= 2 * H;
    endfunction
    function automatic bit exp_busy(input int r);
        return r >= 1 && r <= 17 * H;
    endfunction
    function automatic bit exp_clk(input int r);
        for (int k = 1; k <= 7; k++)
            if (r >= H + 2 * H * k + 1 && r <= 2 * H + 2 * H * k) return 1'b1;
        return 1'b0;
    endfunction

    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
    endtask

    // Observe n cycles after edge 0; start stays high for c<hold and pulses at pa/pb.
    task automatic window(input int n, input int hold, input int pa, input int pb, input bit rnd);
        bit pl = 1'b0, pc = 1'b0;
        int r;
        latch_rises = 0; clk_rises = 0; tl_err = 0;
        vcyc.delete(); vbtn.delete();
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            r = (hold > 1) ? ((c - 1) % P) + 1 : c;
            if (nes_latch && !pl) latch_rises++;
            if (nes_clk && !pc) clk_rises++;
            pl = nes_latch; pc = nes_clk;
            if (nes_latch !== exp_latch(r) || nes_clk !== exp_clk(r) ||
                busy !== exp_busy(r) || valid !== (r == LAT)) tl_err++;
            if (valid === 1'b1) begin
                vcyc.push_back(c);
                vbtn.push_back(int'(buttons));
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL scoreboard: valid at cycle %0d with no latched pattern", c);
                end else begin
                    chk("scoreboard", int'(buttons), int'(exp_q.pop_front()));
                end
                if (rnd) pins = 8'($urandom);
            end
            start = (c < hold) || (c == pa) || (c == pb);
        end
        start = 1'b0;
    endtask

    task automatic check_read(input string name, input logic [7:0] exp_btn);
        chk({name, "_latch_pulses"}, latch_rises, 1);
        chk({name, "_clk_pulses"}, clk_rises, 7);
        chk({name, "_timeline_errs"}, tl_err, 0);
        chk({name, "_valid_count"}, vcyc.size(), 1);
        if (vcyc.size() >= 1) begin
            chk({name, "_valid_cycle"}, vcyc[0], LAT);
            chk({name, "_buttons"}, vbtn[0], int'(exp_btn));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int quiet_err;
        logic [7:0] p;

        tbl[0] = '{8'h7E, 8'h81};
        tbl[1] = '{8'hFF, 8'h00};
        tbl[2] = '{8'h00, 8'hFF};
        tbl[3] = '{8'hFE, 8'h01};
        tbl[4] = '{8'h7F, 8'h80};
        tbl[5] = '{8'hA5, 8'h5A};

        // Reset state and idle quiet.
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_latch", int'(nes_latch), 0);
        chk("rst_clk", int'(nes_clk), 0);
        chk("rst_buttons", int'(buttons), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_busy", int'(busy), 0);
        quiet_err = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (nes_latch || nes_clk || valid || busy || buttons != 8'h00) quiet_err++;
        end
        chk("idle_quiet", quiet_err, 0);

        // A + Right pressed.
        pins = 8'h7E; kick(); window(75, 1, 0, 0, 0);
        check_read("a_right", 8'h81);

        // Unplugged pad.
        pins = 8'hFF; kick(); window(75, 1, 0, 0, 0);
        check_read("unplugged", 8'h00);

        foreach (tbl[i]) begin
            pins = tbl[i].pat; kick(); window(75, 1, 0, 0, 0);
            check_read($sformatf("tbl%0d", i), tbl[i].exp_btn);
        end

        for (int i = 0; i < 6; i++) begin
            p = 8'($urandom);
            pins = p; kick(); window(75, 1, 0, 0, 0);
            check_read($sformatf("rnd%0d", i), ~p);
        end

        // start while busy is ignored.
        pins = 8'h3C; kick(); window(75, 1, 10, 40, 0);
        check_read("busy_start", 8'hC3);

        // Reset mid-read with an all-pressed pattern.
        pins = 8'h00; kick(); window(29, 1, 0, 0, 0);
        @(negedge clk);
        chk("pre_reset_busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        chk("midrst_latch", int'(nes_latch), 0);
        chk("midrst_clk", int'(nes_clk), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_valid", int'(valid), 0);
        chk("midrst_buttons", int'(buttons), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        quiet_err = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (valid || busy || buttons != 8'h00) quiet_err++;
        end
        chk("post_reset_quiet", quiet_err, 0);
        kick(); window(75, 1, 0, 0, 0);
        check_read("after_reset", 8'hFF);

        // start held high: back-to-back reads, pattern changes between reads.
        pins = 8'($urandom); kick(); window(350, 300, 0, 0, 1);
        chk("b2b_latch_pulses", latch_rises, 5);
        chk("b2b_clk_pulses", clk_rises, 35);
        chk("b2b_timeline_errs", tl_err, 0);
        chk("b2b_valid_count", vcyc.size(), 5);
        for (int i = 0; i < 4 && i < vcyc.size(); i++)
            chk($sformatf("b2b_valid_cycle%0d", i), vcyc[i], LAT + i * P);

        chk("sb_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
